// File: rtl/prm_edge_chk_sched.sv
// prm_edge_chk_sched: scans one edge query across a banked combinational checker array
// and returns the collected edge masks over a valid/ready response channel.
module prm_edge_chk_sched #(
  parameter int IN_W       = 15,
  parameter int BANK_W     = 8,
  parameter int NUM_BANKS  = 4,
  parameter int EARLY_EXIT = 1,
  parameter int CNT_W      = 16,
  localparam int RES_W     = BANK_W * NUM_BANKS,
  localparam int SEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int BNK_W     = $clog2(NUM_BANKS) + 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IN_W-1:0]  req_vec,
  input  logic             abort,
  output logic [IN_W-1:0]  chk_vec,
  output logic [SEL_W-1:0] chk_bank_sel,
  output logic             chk_en,
  input  logic [BANK_W-1:0] chk_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_mask,
  output logic             rsp_hit,
  output logic [BNK_W-1:0] rsp_banks,
  output logic [CNT_W-1:0] stat_queries,
  output logic [CNT_W-1:0] stat_hits
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic last, hit_now;
  assign req_ready = (state == IDLE);
  assign chk_en    = (state == SCAN);
  assign rsp_valid = (state == DONE);
  assign hit_now   = |chk_mask;
  assign last      = (chk_bank_sel == SEL_W'(NUM_BANKS - 1)) || ((EARLY_EXIT != 0) && hit_now);
  // abort wins over everything, including a pending request in IDLE
  always_comb begin
    state_nx = abort                          ? IDLE :
               (state == IDLE && req_valid)   ? SCAN :
               (state == SCAN && last)        ? DONE :
               (state == DONE && rsp_ready)   ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state        <= IDLE;
      chk_vec      <= '0;
      chk_bank_sel <= '0;
      rsp_mask     <= '0;
      rsp_hit      <= 1'b0;
      rsp_banks    <= '0;
      stat_queries <= '0;
      stat_hits    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid && !abort) begin
        chk_vec      <= req_vec;
        chk_bank_sel <= '0;
        rsp_mask     <= '0;
        rsp_hit      <= 1'b0;
        rsp_banks    <= '0;
      end
      if (state == SCAN && !abort) begin
        rsp_mask[chk_bank_sel*BANK_W +: BANK_W] <= chk_mask;
        rsp_hit   <= rsp_hit | hit_now;
        rsp_banks <= BNK_W'(chk_bank_sel) + BNK_W'(1);
        if (!last) chk_bank_sel <= chk_bank_sel + SEL_W'(1);
        if (last) begin
          stat_queries <= &stat_queries ? stat_queries : stat_queries + CNT_W'(1);
          if (rsp_hit | hit_now) stat_hits <= &stat_hits ? stat_hits : stat_hits + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// tb_prm_edge_chk_sched: scoreboard bench; u0 early-exit with 16-bit stats,
// u1 full-scan with 4-bit stats to reach saturation quickly.
module tb_prm_edge_chk_sched;
  typedef struct {logic [31:0] mask; logic hit; logic [2:0] banks; int t;} exp_t;
  exp_t q0[$], q1[$];
  int ncmp = 0, nerr = 0, cyc = 0, hs0 = 0, acc = 0, eq0 = 0, eh0 = 0;
  logic CLK, RST_n = 1'b0;
  logic req_valid = 1'b0, req_valid1 = 1'b0, abort = 1'b0, rsp_ready = 1'b1;
  logic [14:0] req_vec = '0;
  logic [7:0] bm [4];
  logic req_ready0, chk_en0, rsp_valid0, rsp_hit0, pv0 = 1'b0;
  logic [14:0] chk_vec0;
  logic [1:0] sel0;
  logic [7:0] chk_mask0;
  logic [31:0] rsp_mask0;
  logic [2:0] rsp_banks0;
  logic [15:0] sq0, sh0;
  logic req_ready1, chk_en1, rsp_valid1, rsp_hit1, pv1 = 1'b0;
  logic [14:0] chk_vec1;
  logic [1:0] sel1;
  logic [7:0] chk_mask1;
  logic [31:0] rsp_mask1;
  logic [2:0] rsp_banks1;
  logic [3:0] sq1, sh1;
  assign chk_mask0 = chk_en0 ? bm[sel0] : 8'h00;
  assign chk_mask1 = chk_en1 ? bm[sel1] : 8'h00;
  prm_edge_chk_sched #(.EARLY_EXIT(1), .CNT_W(16)) u0 (
    .CLK(CLK), .RST_n(RST_n), .req_valid(req_valid), .req_ready(req_ready0), .req_vec(req_vec),
    .abort(abort), .chk_vec(chk_vec0), .chk_bank_sel(sel0), .chk_en(chk_en0), .chk_mask(chk_mask0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask0), .rsp_hit(rsp_hit0),
    .rsp_banks(rsp_banks0), .stat_queries(sq0), .stat_hits(sh0));
  prm_edge_chk_sched #(.EARLY_EXIT(0), .CNT_W(4)) u1 (
    .CLK(CLK), .RST_n(RST_n), .req_valid(req_valid1), .req_ready(req_ready1), .req_vec(req_vec),
    .abort(1'b0), .chk_vec(chk_vec1), .chk_bank_sel(sel1), .chk_en(chk_en1), .chk_mask(chk_mask1),
    .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_mask(rsp_mask1), .rsp_hit(rsp_hit1),
    .rsp_banks(rsp_banks1), .stat_queries(sq1), .stat_hits(sh1));
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic cmp_rsp(input string p, input logic [31:0] m, input logic h, input logic [2:0] b, input exp_t e);
    chk({p, " mask"}, m, e.mask);
    chk({p, " hit"}, 32'(h), 32'(e.hit));
    chk({p, " banks"}, 32'(b), 32'(e.banks));
    chk({p, " latency"}, cyc, e.t);
  endtask
  // monitor: one pop per new response, compared on the first valid cycle
  always @(negedge CLK) begin
    exp_t e;
    if (rsp_valid0 && !pv0) begin
      if (q0.size() == 0) chk("u0 unexpected rsp", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        cmp_rsp("u0", rsp_mask0, rsp_hit0, rsp_banks0, e);
      end
    end
    if (rsp_valid1 && !pv1) begin
      if (q1.size() == 0) chk("u1 unexpected rsp", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        cmp_rsp("u1", rsp_mask1, rsp_hit1, rsp_banks1, e);
      end
    end
    if (rsp_valid0 && rsp_ready) hs0 = cyc;
    pv0 = rsp_valid0;
    pv1 = rsp_valid1;
  end
  task automatic send(input int d, input logic [14:0] v, input logic [31:0] m, input logic h,
                      input logic [2:0] b, input int lat, input bit push, input bit keep, output int a);
    int n = 0;
    exp_t e;
    req_vec = v;
    if (d == 0) req_valid = 1'b1; else req_valid1 = 1'b1;
    while (!(d == 0 ? req_ready0 : req_ready1) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) chk("send timeout", 32'd1, 32'd0);
    a = cyc;
    e.mask = m; e.hit = h; e.banks = b; e.t = a + lat;
    if (push && d == 0) q0.push_back(e);
    if (push && d != 0) q1.push_back(e);
    @(negedge CLK);
    if (!keep) begin
      req_valid = 1'b0;
      req_valid1 = 1'b0;
    end
  endtask
  task automatic wait_done(input int d);
    int n = 0;
    while (!((d == 0 ? q0.size() : q1.size()) == 0 && (d == 0 ? req_ready0 : req_ready1)) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n == 100) chk("done timeout", 32'd1, 32'd0);
  endtask
  initial begin
    bm = '{default: 8'h00};
    repeat (2) @(negedge CLK);
    chk("reset req_ready", 32'(req_ready0), 32'd1);
    chk("reset chk_en", 32'(chk_en0), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("reset stat_queries", 32'(sq0), 32'd0);
    RST_n = 1'b1;
    @(negedge CLK);
    // full scan, no hits
    send(0, 15'h5A3C, 32'h0, 1'b0, 3'd4, 5, 1, 0, acc);
    chk("scan chk_en", 32'(chk_en0), 32'd1);
    chk("scan chk_vec", 32'(chk_vec0), 32'h5A3C);
    wait_done(0);
    eq0 = 1;
    chk("t1 stat_queries", 32'(sq0), 32'(eq0));
    chk("t1 stat_hits", 32'(sh0), 32'(eh0));
    // early exit at bank 2
    bm[2] = 8'h10;
    send(0, 15'h1234, 32'h0010_0000, 1'b1, 3'd3, 4, 1, 0, acc);
    wait_done(0);
    eq0 = 2; eh0 = 1;
    chk("t2 stat_queries", 32'(sq0), 32'(eq0));
    chk("t2 stat_hits", 32'(sh0), 32'(eh0));
    // consumer stalls: response and req_ready must hold
    bm[2] = 8'h00; bm[1] = 8'hA5;
    rsp_ready = 1'b0;
    send(0, 15'h0F0F, 32'h0000_A500, 1'b1, 3'd2, 3, 1, 0, acc);
    for (int i = 0; i < 10 && !rsp_valid0; i++) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      chk("hold rsp_valid", 32'(rsp_valid0), 32'd1);
      chk("hold req_ready", 32'(req_ready0), 32'd0);
      chk("hold rsp_mask", rsp_mask0, 32'h0000_A500);
      @(negedge CLK);
    end
    rsp_ready = 1'b1;
    wait_done(0);
    eq0 = 3; eh0 = 2;
    // back-to-back: exactly one idle cycle after the handshake
    bm[1] = 8'h00; bm[0] = 8'h03;
    send(0, 15'h0101, 32'h0000_0003, 1'b1, 3'd1, 2, 1, 1, acc);
    send(0, 15'h0202, 32'h0000_0003, 1'b1, 3'd1, 2, 1, 0, acc);
    chk("b2b idle gap", 32'(acc - hs0), 32'd1);
    wait_done(0);
    eq0 = 5; eh0 = 4;
    chk("b2b stat_queries", 32'(sq0), 32'(eq0));
    // abort at bank 1
    bm[0] = 8'h00;
    send(0, 15'h7777, 32'h0, 1'b0, 3'd0, 0, 0, 0, acc);
    @(negedge CLK);
    chk("abort at bank", 32'(sel0), 32'd1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort req_ready", 32'(req_ready0), 32'd1);
    chk("abort chk_en", 32'(chk_en0), 32'd0);
    repeat (6) @(negedge CLK);
    chk("abort stat_queries", 32'(sq0), 32'(eq0));
    chk("abort stat_hits", 32'(sh0), 32'(eh0));
    // abort in IDLE blocks acceptance
    req_valid = 1'b1; abort = 1'b1;
    @(negedge CLK);
    chk("idle abort priority", 32'(req_ready0), 32'd1);
    req_valid = 1'b0; abort = 1'b0;
    @(negedge CLK);
    // async reset mid-scan
    send(0, 15'h4321, 32'h0, 1'b0, 3'd0, 0, 0, 0, acc);
    @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    chk("arst chk_en", 32'(chk_en0), 32'd0);
    chk("arst req_ready", 32'(req_ready0), 32'd1);
    chk("arst chk_vec", 32'(chk_vec0), 32'd0);
    chk("arst sel", 32'(sel0), 32'd0);
    chk("arst rsp_banks", 32'(rsp_banks0), 32'd0);
    chk("arst stat_queries", 32'(sq0), 32'd0);
    chk("arst stat_hits", 32'(sh0), 32'd0);
    eq0 = 0; eh0 = 0;
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    bm[3] = 8'hFF;
    send(0, 15'h0001, 32'hFF00_0000, 1'b1, 3'd4, 5, 1, 0, acc);
    wait_done(0);
    chk("recover stat_queries", 32'(sq0), 32'd1);
    chk("recover stat_hits", 32'(sh0), 32'd1);
    // no early exit: later banks still scanned after a hit
    bm[2] = 8'h10; bm[3] = 8'h01;
    send(1, 15'h2468, 32'h0110_0000, 1'b1, 3'd4, 5, 1, 0, acc);
    wait_done(1);
    chk("u1 stat_queries", 32'(sq1), 32'd1);
    for (int i = 0; i < 16; i++) begin
      send(1, 15'(i), 32'h0110_0000, 1'b1, 3'd4, 5, 1, 0, acc);
      wait_done(1);
    end
    chk("sat stat_queries", 32'(sq1), 32'hF);
    chk("sat stat_hits", 32'(sh1), 32'hF);
    chk("u0 queue drained", 32'(q0.size()), 32'd0);
    chk("u1 queue drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
